// File: rtl/core_seq_pkg.sv
// Shared definitions for the multi-cycle core sequencer: state encoding,
// the opcodes the sequencer understands, and the reset value of the
// instruction register.
package core_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // True for every opcode the sequencer knows how to step through.
  function automatic logic is_known_op(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multi_cycle_core_seq_mem_handshake_if.sv
// Request/ready handshake holder. A one-cycle launch captures the payload
// (address, and for data accesses the write flag and write data) and raises
// req; both stay stable until the memory answers with ready, so memories
// of any latency can be attached. An asynchronous reset drops req at once.
module mem_handshake_if #(
  parameter int            W             = 32,
  parameter logic [W-1:0]  RESET_PAYLOAD = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         launch,
  input  logic [W-1:0] launch_payload,
  input  logic         ready,
  output logic         req,
  output logic [W-1:0] payload,
  output logic         done
);

  // A transfer completes only when a request is actually outstanding.
  assign done = req & ready;

  // Hold the request and its payload from launch until the memory is ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req     <= 1'b0;
      payload <= RESET_PAYLOAD;
    end else if (launch) begin
      req     <= 1'b1;
      payload <= launch_payload;
    end else if (done) begin
      req     <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_cycle_core_seq.sv
// Multi-cycle core sequencer: owns the PC, the instruction register and the
// FETCH/DECODE/EXECUTE/MEM/WB/HALT state machine, and gates the register
// file write. Instruction and data memories are reached through req/ready
// handshakes (mem_handshake_if), so their latency is arbitrary.
// Optional feature macro: PERF_CNT_EN adds 64-bit cycle_cnt and
// instret_cnt outputs; without it those ports and counters do not exist.
module multi_cycle_core_seq
  import core_seq_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_PC     = '0,
  parameter bit               ILLEGAL_HALT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm_ext,
  input  logic            branch_taken,
  output logic            rf_we,
  output logic [XLEN-1:0] wb_data,
  output logic [2:0]      state_o,
`ifdef PERF_CNT_EN
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt,
`endif
  output logic            halted
);

  state_t                  state;
  logic [6:0]              opcode;
  logic                    is_load;
  logic                    is_store;
  logic                    is_branch;
  logic                    is_jal;
  logic                    known_op;
  logic [XLEN-1:0]         pc_plus4;
  logic [XLEN-1:0]         pc_plus_imm;
  logic [XLEN-1:0]         pc_next;
  logic                    retire;
  logic                    fetch_launch;
  logic                    dmem_launch;
  logic                    imem_done;
  logic                    dmem_done;
  logic [2*XLEN:0]         dmem_hold;

  assign opcode      = instr[6:0];
  assign is_load     = (opcode == OP_LOAD);
  assign is_store    = (opcode == OP_STORE);
  assign is_branch   = (opcode == OP_BRANCH);
  assign is_jal      = (opcode == OP_JAL);
  assign known_op    = is_known_op(opcode);
  assign pc_plus4    = pc + XLEN'(4);
  assign pc_plus_imm = pc + imm_ext;
  assign state_o     = state;

  // Work out where the PC goes next and when a new fetch or data access
  // must be launched, so the request is already up in the first cycle of
  // FETCH/MEM. The only fetch without a retiring instruction is the first
  // one after reset, when FETCH is entered with no request outstanding.
  always_comb begin
    pc_next      = pc;
    retire       = 1'b0;
    fetch_launch = 1'b0;
    case (state)
      ST_FETCH:   fetch_launch = !imem_req;
      ST_DECODE:  if (!known_op && !ILLEGAL_HALT) begin
                    pc_next = pc_plus4;
                    retire  = 1'b1;
                  end
      ST_EXECUTE: if (is_branch) begin
                    pc_next = branch_taken ? pc_plus_imm : pc_plus4;
                    retire  = 1'b1;
                  end
      ST_MEM:     if (dmem_done && is_store) begin
                    pc_next = pc_plus4;
                    retire  = 1'b1;
                  end
      ST_WB:      begin
                    pc_next = is_jal ? pc_plus_imm : pc_plus4;
                    retire  = 1'b1;
                  end
      default:    pc_next = pc;
    endcase
    fetch_launch = fetch_launch | retire;
    dmem_launch  = (state == ST_EXECUTE) && (is_load || is_store);
  end

  mem_handshake_if #(
    .W             (XLEN),
    .RESET_PAYLOAD (RESET_PC)
  ) u_imem_hs (
    .clk            (clk),
    .rst            (rst),
    .launch         (fetch_launch),
    .launch_payload (pc_next),
    .ready          (imem_ready),
    .req            (imem_req),
    .payload        (imem_addr),
    .done           (imem_done)
  );

  mem_handshake_if #(
    .W             (2*XLEN+1),
    .RESET_PAYLOAD ('0)
  ) u_dmem_hs (
    .clk            (clk),
    .rst            (rst),
    .launch         (dmem_launch),
    .launch_payload ({is_store, alu_result, rs2_data}),
    .ready          (dmem_ready),
    .req            (dmem_req),
    .payload        (dmem_hold),
    .done           (dmem_done)
  );

  assign {dmem_we, dmem_addr, dmem_wdata} = dmem_hold;

  // Main sequencer: state, PC, instruction register and registered
  // write-back outputs; rf_we is raised on entry to WB and dropped on exit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_FETCH;
      pc      <= RESET_PC;
      instr   <= NOP_INSTR;
      rf_we   <= 1'b0;
      wb_data <= '0;
      halted  <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      pc    <= pc_next;
      case (state)
        ST_FETCH: begin
          if (imem_done) begin
            instr <= imem_rdata;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (known_op) begin
            state <= ST_EXECUTE;
          end else if (ILLEGAL_HALT) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_EXECUTE: begin
          if (is_load || is_store) begin
            state <= ST_MEM;
          end else if (is_branch) begin
            state <= ST_FETCH;
          end else begin
            state   <= ST_WB;
            rf_we   <= 1'b1;
            wb_data <= is_jal ? pc_plus4 : alu_result;
          end
        end
        ST_MEM: begin
          if (dmem_done) begin
            if (is_store) begin
              state <= ST_FETCH;
            end else begin
              state   <= ST_WB;
              rf_we   <= 1'b1;
              wb_data <= dmem_rdata;
            end
          end
        end
        ST_WB:   state <= ST_FETCH;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_HALT;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  // Cycle and retired-instruction counters, both frozen once halted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= 64'd0;
      instret_cnt <= 64'd0;
    end else if (state != ST_HALT) begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (retire) begin
        instret_cnt <= instret_cnt + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_core_seq.sv
// Self-checking bench for multi_cycle_core_seq (RESET_PC=0x100,
// ILLEGAL_HALT=1). A table of instructions with memory latencies,
// datapath values and hand-computed results is stepped through in order,
// followed by hand-written halt and mid-access reset sequences.
module tb_multi_cycle_core_seq;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic             clk = 1'b0;
  logic             rst;
  logic             imem_req;
  logic [XLEN-1:0]  imem_addr;
  logic             imem_ready;
  logic [31:0]      imem_rdata;
  logic             dmem_req;
  logic             dmem_we;
  logic [XLEN-1:0]  dmem_addr;
  logic [XLEN-1:0]  dmem_wdata;
  logic             dmem_ready;
  logic [XLEN-1:0]  dmem_rdata;
  logic [31:0]      instr;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  alu_result;
  logic [XLEN-1:0]  rs2_data;
  logic [XLEN-1:0]  imm_ext;
  logic             branch_taken;
  logic             rf_we;
  logic [XLEN-1:0]  wb_data;
  logic [2:0]       state_o;
  logic             halted;
`ifdef PERF_CNT_EN
  logic [63:0]      cycle_cnt;
  logic [63:0]      instret_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] instr;
    int          ilat;
    int          dlat;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        taken;
    logic [31:0] rdata;
    logic [31:0] exp_fetch_pc;
    int          exp_cycles;
    int          exp_we_cnt;
    logic [31:0] exp_wb;
    logic        exp_dreq;
    logic        exp_dwe;
    logic [31:0] exp_daddr;
    logic [31:0] exp_dwdata;
    logic [31:0] exp_next_pc;
  } vec_t;

  vec_t vecs[11];

  multi_cycle_core_seq #(
    .XLEN         (XLEN),
    .RESET_PC     (RESET_PC),
    .ILLEGAL_HALT (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ready   (dmem_ready),
    .dmem_rdata   (dmem_rdata),
    .instr        (instr),
    .pc           (pc),
    .alu_result   (alu_result),
    .rs2_data     (rs2_data),
    .imm_ext      (imm_ext),
    .branch_taken (branch_taken),
    .rf_we        (rf_we),
    .wb_data      (wb_data),
    .state_o      (state_o),
`ifdef PERF_CNT_EN
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt),
`endif
    .halted       (halted)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Run one instruction from its first FETCH cycle to the next FETCH entry,
  // acting as both memories, then compare what was observed.
  task automatic applyStimulus(input vec_t v, input int idx);
    int          cyc = 0;
    int          we_cnt = 0;
    int          hold_err = 0;
    int          rfwe_bad = 0;
    int          iwait = 0;
    int          dwait = 0;
    int          dstab = 0;
    logic        left = 1'b0;
    logic        done = 1'b0;
    logic        dreq_seen = 1'b0;
    logic        dwe_seen = 1'b0;
    logic [31:0] wb_seen = '0;
    logic [31:0] daddr_seen = '0;
    logic [31:0] dwdata_seen = '0;
    logic [31:0] instr_seen = '0;
    alu_result   = v.alu;
    rs2_data     = v.rs2;
    imm_ext      = v.imm;
    branch_taken = v.taken;
    imem_rdata   = v.instr;
    dmem_rdata   = v.rdata;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) begin
        @(negedge clk);
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        if (state_o != 3'd0) left = 1'b1;
        if ((left && state_o == 3'd0) || state_o == 3'd5) begin
          done = 1'b1;
          break;
        end
      end
      cyc++;
      if (state_o == 3'd1) instr_seen = instr;
      if (rf_we) begin
        we_cnt++;
        wb_seen = wb_data;
        if (state_o != 3'd4) rfwe_bad++;
      end
      if (imem_req) begin
        if (imem_addr != v.exp_fetch_pc) hold_err++;
        if (iwait == v.ilat) imem_ready = 1'b1;
        else iwait++;
      end
      if (dmem_req) begin
        if (!dreq_seen) begin
          dreq_seen   = 1'b1;
          dwe_seen    = dmem_we;
          daddr_seen  = dmem_addr;
          dwdata_seen = dmem_wdata;
        end else if ({dmem_we, dmem_addr, dmem_wdata} !=
                     {dwe_seen, daddr_seen, dwdata_seen}) begin
          dstab++;
        end
        if (dwait == v.dlat) dmem_ready = 1'b1;
        else dwait++;
      end
    end
    checkOutput($sformatf("v%0d.finished", idx), done, 1'b1);
    checkOutput($sformatf("v%0d.cycles", idx), cyc, v.exp_cycles);
    checkOutput($sformatf("v%0d.instr", idx), instr_seen, v.instr);
    checkOutput($sformatf("v%0d.rf_we_pulses", idx), we_cnt, v.exp_we_cnt);
    checkOutput($sformatf("v%0d.rf_we_outside_wb", idx), rfwe_bad, 0);
    checkOutput($sformatf("v%0d.imem_addr_hold", idx), hold_err, 0);
    if (v.exp_we_cnt > 0)
      checkOutput($sformatf("v%0d.wb_data", idx), wb_seen, v.exp_wb);
    checkOutput($sformatf("v%0d.dmem_req", idx), dreq_seen, v.exp_dreq);
    if (v.exp_dreq) begin
      checkOutput($sformatf("v%0d.dmem_we", idx), dwe_seen, v.exp_dwe);
      checkOutput($sformatf("v%0d.dmem_addr", idx), daddr_seen, v.exp_daddr);
      checkOutput($sformatf("v%0d.dmem_wdata", idx), dwdata_seen, v.exp_dwdata);
      checkOutput($sformatf("v%0d.dmem_stable", idx), dstab, 0);
    end
    checkOutput($sformatf("v%0d.next_pc", idx), pc, v.exp_next_pc);
    checkOutput($sformatf("v%0d.next_fetch_addr", idx), imem_addr, v.exp_next_pc);
    checkOutput($sformatf("v%0d.next_fetch_req", idx), imem_req, 1'b1);
  endtask

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence: reset, instruction table, halt, mid-access reset.
  initial begin
    int steps;
    int leaks;

    // instr, ilat, dlat, alu, rs2, imm, taken, rdata,
    // fetch_pc, cycles, we_cnt, wb, dreq, dwe, daddr, dwdata, next_pc
    vecs[0]  = '{32'h00700093, 3, 0, 32'h7, 32'h0, 32'h0, 1'b0, 32'h0,
                 32'h100, 7, 1, 32'h7, 1'b0, 1'b0, 32'h0, 32'h0, 32'h104};
    vecs[1]  = '{32'h0000A103, 0, 2, 32'h200, 32'h11111111, 32'h0, 1'b0, 32'hDEADBEEF,
                 32'h104, 7, 1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h200, 32'h11111111, 32'h108};
    vecs[2]  = '{32'h0020A223, 0, 0, 32'h204, 32'hCAFEF00D, 32'h0, 1'b0, 32'h0,
                 32'h108, 4, 0, 32'h0, 1'b1, 1'b1, 32'h204, 32'hCAFEF00D, 32'h10C};
    vecs[3]  = '{32'h002081B3, 1, 0, 32'h12345678, 32'h0, 32'h0, 1'b0, 32'h0,
                 32'h10C, 5, 1, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0, 32'h110};
    vecs[4]  = '{32'h00208463, 0, 0, 32'h0, 32'h0, 32'hFFFFFF00, 1'b1, 32'h0,
                 32'h110, 3, 0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h010};
    vecs[5]  = '{32'h00208463, 0, 0, 32'h0, 32'h0, 32'hFFFFFFF8, 1'b1, 32'h0,
                 32'h010, 3, 0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h008};
    vecs[6]  = '{32'h008000EF, 0, 0, 32'hBAD, 32'h0, 32'h8, 1'b0, 32'h0,
                 32'h008, 4, 1, 32'h00C, 1'b0, 1'b0, 32'h0, 32'h0, 32'h010};
    vecs[7]  = '{32'h00208463, 0, 0, 32'h0, 32'h0, 32'hFFFFFFF8, 1'b0, 32'h0,
                 32'h010, 3, 0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h014};
    vecs[8]  = '{32'h00208463, 0, 0, 32'h0, 32'h0, 32'hFFFFFFE8, 1'b1, 32'h0,
                 32'h014, 3, 0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFFFFFC};
    vecs[9]  = '{32'h00100093, 0, 0, 32'h1, 32'h0, 32'h0, 1'b0, 32'h0,
                 32'hFFFFFFFC, 4, 1, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h000};
    vecs[10] = '{32'h008000EF, 0, 0, 32'hBAD, 32'h0, 32'h100, 1'b0, 32'h0,
                 32'h000, 4, 1, 32'h004, 1'b0, 1'b0, 32'h0, 32'h0, 32'h100};

    rst = 1'b0;
    imem_ready = 1'b0; imem_rdata = '0;
    dmem_ready = 1'b0; dmem_rdata = '0;
    alu_result = '0; rs2_data = '0; imm_ext = '0; branch_taken = 1'b0;

    @(negedge clk);
    checkOutput("reset.imem_req", imem_req, 1'b0);
    checkOutput("reset.dmem_req", dmem_req, 1'b0);
    checkOutput("reset.dmem_we", dmem_we, 1'b0);
    checkOutput("reset.rf_we", rf_we, 1'b0);
    checkOutput("reset.wb_data", wb_data, 32'h0);
    checkOutput("reset.pc", pc, RESET_PC);
    checkOutput("reset.instr", instr, 32'h00000013);
    checkOutput("reset.state", state_o, 3'd0);
    checkOutput("reset.halted", halted, 1'b0);
    rst = 1'b1;

    @(negedge clk);
    checkOutput("boot.imem_req", imem_req, 1'b1);
    checkOutput("boot.imem_addr", imem_addr, RESET_PC);
    checkOutput("boot.rf_we", rf_we, 1'b0);

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

`ifdef PERF_CNT_EN
    checkOutput("perf.instret", instret_cnt, 64'd11);
    checkOutput("perf.cycles", cycle_cnt, 64'd48);
`endif

    // Unknown opcode 0x7F at pc 0x100: halt and stay quiet.
    imem_rdata = 32'h0000007F;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    checkOutput("halt.state", state_o, 3'd5);
    checkOutput("halt.halted", halted, 1'b1);
    checkOutput("halt.imem_req", imem_req, 1'b0);
    leaks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (imem_req || dmem_req || rf_we || state_o != 3'd5 || !halted) leaks++;
    end
    checkOutput("halt.absorbing", leaks, 0);
    checkOutput("halt.pc", pc, 32'h100);

    // Reset out of HALT, then start a load and reset in the middle of MEM.
    rst = 1'b0;
    #1;
    checkOutput("rehalt.halted", halted, 1'b0);
    checkOutput("rehalt.state", state_o, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("restart1.imem_req", imem_req, 1'b1);
    alu_result = 32'h300;
    imem_rdata = 32'h0000A103;
    imem_ready = 1'b1;
    steps = 0;
    while (!dmem_req && steps < 10) begin
      @(negedge clk);
      imem_ready = 1'b0;
      steps++;
    end
    checkOutput("midreset.dmem_req_before", dmem_req, 1'b1);
    checkOutput("midreset.dmem_addr_before", dmem_addr, 32'h300);
    rst = 1'b0;
    #1;
    checkOutput("midreset.dmem_req", dmem_req, 1'b0);
    checkOutput("midreset.imem_req", imem_req, 1'b0);
    checkOutput("midreset.rf_we", rf_we, 1'b0);
    checkOutput("midreset.state", state_o, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("restart2.imem_req", imem_req, 1'b1);
    checkOutput("restart2.imem_addr", imem_addr, RESET_PC);
    checkOutput("restart2.pc", pc, RESET_PC);
    checkOutput("restart2.dmem_req", dmem_req, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_core_seq.md
Name: multi_cycle_core_seq

Overview:
Parametrised multi-cycle successor to the single-cycle core top. It owns the PC, the instruction register and the FETCH/DECODE/EXECUTE/MEM/WB state machine. It talks to instruction and data memories over req/ready handshakes, so memories may have any latency. Decoding, ALU, register file and immediate generation stay in the existing datapath blocks. This block sequences them and gates their enables.

Parameters:
XLEN, 32, data/address width
RESET_PC, 0, PC value loaded on reset
ILLEGAL_HALT, 1, 1 = halt on unknown opcode; 0 = treat as NOP

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
imem_req  out  1  fetch request
imem_addr  out  XLEN  fetch address (= pc)
imem_ready  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction
dmem_req  out  1  data access request
dmem_we  out  1  1 = store
dmem_addr  out  XLEN  = alu_result latched in EXECUTE
dmem_wdata  out  XLEN  = rs2_data latched in EXECUTE
dmem_ready  in  1  access complete; dmem_rdata valid this cycle
dmem_rdata  in  XLEN  load data
instr  out  32  instruction register to decoder/regfile/sign-extend
pc  out  XLEN  current PC
alu_result  in  XLEN  datapath ALU output
rs2_data  in  XLEN  register file RD2
imm_ext  in  XLEN  sign-extended immediate
branch_taken  in  1  branch condition from ALU flags
rf_we  out  1  register-file write enable, one cycle pulse
wb_data  out  XLEN  register write data
state_o  out  3  current state, for debug
halted  out  1  sticky; set on illegal opcode

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, instr=32'h00000013 (NOP), state=FETCH. All req/we/rf_we=0, wb_data=0, halted=0. Mid-transaction reset abandons the access; imem_req/dmem_req drop immediately.
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5.
- FETCH: imem_req=1, addr=pc held stable until imem_ready. On ready, instr<=imem_rdata and go to DECODE. imem_ready with no req is ignored.
- DECODE: one cycle for datapath settling.
  - Opcode 0110011/0010011/0000011/0100011/1100011/1101111 → EXECUTE.
  - Otherwise → HALT if ILLEGAL_HALT, else pc<=pc+4 and go to FETCH.
- EXECUTE: latch alu_result and rs2_data.
  - Load/store → MEM.
  - Branch: pc <= branch_taken ? pc+imm_ext : pc+4, then → FETCH.
  - Others → WB.
- MEM: dmem_req=1, dmem_we=(store), addr/wdata stable until dmem_ready.
  - Store: on ready, pc<=pc+4 and go to FETCH.
  - Load: on ready, latch dmem_rdata and go to WB.
- WB: rf_we=1 for exactly one cycle.
  - wb_data = load ? latched rdata : JAL ? pc+4 : latched alu_result.
  - pc <= JAL ? pc+imm_ext : pc+4.
  - Then → FETCH.
- HALT: absorbing; only reset exits. halted=1, no requests.
- PC arithmetic is modulo 2^XLEN; wrap at the top of the address space is silent.
- CPI: ALU=4, load=5, store=4, branch=3, JAL=4 (plus memory wait cycles).
- rf_we never asserts outside WB. The WB write to x0 is still pulsed; the regfile ignores it.

Optional Feature:
PERF_CNT_EN
- Defined: adds 64-bit outputs cycle_cnt (increments every cycle after reset) and instret_cnt (increments on each FETCH entry that follows a completed instruction). Both clear on reset; both freeze in HALT.
- Undefined: ports and logic are absent.

Decomposition:
- Package core_seq_pkg: state encoding localparams, opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL), NOP constant.
- One natural sub-module, mem_handshake_if: holds req/addr/wdata stable until ready. Instantiated twice (imem, dmem).

Test Plan:
- Reset with RESET_PC=0x100, release → imem_req=1, imem_addr=0x100 on first cycle; rf_we=0.
- addi fetched, imem_ready delayed 3 cycles, alu_result=7 → addr held 3 cycles; rf_we pulses once with wb_data=7; pc=0x104.
- lw, dmem_ready after 2 cycles, dmem_rdata=0xDEADBEEF → dmem_we=0; wb_data=0xDEADBEEF; total 7 cycles.
- beq with branch_taken=1, imm_ext=-8 at pc=0x10 → pc=0x08, no rf_we; with taken=0 → pc=0x14.
- Opcode 0x7F with ILLEGAL_HALT=1 → state_o=5, halted=1, no further imem_req.
- rst asserted while dmem_req=1 → dmem_req=0 same cycle; restart fetches at RESET_PC.
